// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per PC,
// holds the returned word for decode, and drives the external PC register.
// Supports redirect (branch/jump) squashing and halts on a misaligned PC.
module fetch_unit #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_SQUASH,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] seq_pc;

  // Next-state and datapath capture; redirect outranks every other event.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_IDLE: begin
        if (!redirect) begin
          if (pc_in[1:0] == 2'b00) begin
            addr_d  = pc_in;
            state_d = S_REQ;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_REQ: begin
        if (redirect) begin
          // An ack in the same cycle completes the request, so nothing is
          // left outstanding and the data is simply dropped.
          state_d = imem_ack ? S_IDLE : S_SQUASH;
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = addr_q;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || inst_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SQUASH: begin
        // Wait out the stale request; its data never reaches decode.
        if (!redirect && imem_ack) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (redirect) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the data registers are reset too because their values are
      // visible on the ports while idle and must read as zero after reset.
      state_q   <= S_IDLE;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // PC register control: combinational so the PC loads on the same edge.
  always_comb begin
    seq_pc    = addr_q + PC_STEP;  // 32-bit modulo wrap is intended
    pc_next   = redirect ? redirect_pc : seq_pc;
    pc_enable = rst && (redirect || ((state_q == S_REQ) && imem_ack));
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_SQUASH);
  assign imem_addr   = addr_q;
  assign inst_valid  = (state_q == S_HOLD);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_fault = (state_q == S_FAULT);

endmodule
